// File: rtl/trace_record_serializer.sv
// trace_record_serializer
//   Takes one 512-bit v1.2 trace record per handshake and emits it as eight 64-bit beats, MSB first,
//   with out_last on beat 7. Inserts a heartbeat record after HB_PERIOD idle cycles so the collector
//   can tell a quiet shell from a dead one. All outputs are registered.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream record handshake, in_record is the 512-bit record
//   now_ts               free-running timestamp, stamped into heartbeat t_ingress
//   out_valid/out_ready  downstream beat handshake, out_data/out_last carry the beat
//   rec_count, hb_count  records (data + heartbeat) and heartbeats fully emitted, wrapping

module trace_record_serializer #(
  parameter int unsigned HB_PERIOD = 1024,
  parameter logic [15:0] CORE_ID   = 16'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_record,
  input  logic [63:0]  now_ts,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_last,
  output logic [31:0]  rec_count,
  output logic [31:0]  hb_count
);

  localparam bit          HbEnable = (HB_PERIOD != 0);
  localparam logic [31:0] HbLast   = HbEnable ? 32'(HB_PERIOD - 1) : 32'd0;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e        state_q;
  logic [511:0]  shift_q;     // beats not yet presented, next beat in the top 64 bits
  logic [2:0]    beat_q;
  logic [31:0]   idle_cnt_q;
  logic          is_hb_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [63:0]   out_data_q;
  logic          out_last_q;
  logic [31:0]   rec_count_q;
  logic [31:0]   hb_count_q;

  logic          accept;
  logic          hb_due;
  logic [511:0]  hb_record;

  assign accept = (state_q == StIdle) && in_valid && in_ready_q;
  assign hb_due = HbEnable && (state_q == StIdle) && !in_valid && (idle_cnt_q == HbLast);

  // Heartbeat: version 2, type 4, seq_no = heartbeats so far, t_ingress = now_ts, flags = valid.
  assign hb_record = {8'h02, 8'h04, CORE_ID, hb_count_q, now_ts, 144'h0, 16'h0001, 224'h0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      beat_q      <= '0;
      idle_cnt_q  <= '0;
      is_hb_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      rec_count_q <= '0;
      hb_count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Data has priority over a heartbeat falling due in the same cycle.
          if (accept || hb_due) begin
            state_q     <= StSend;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            beat_q      <= '0;
            idle_cnt_q  <= '0;
            is_hb_q     <= !accept;
            if (accept) begin
              out_data_q <= in_record[511:448];
              shift_q    <= {in_record[447:0], 64'h0};
            end else begin
              out_data_q <= hb_record[511:448];
              shift_q    <= {hb_record[447:0], 64'h0};
            end
          end else begin
            in_ready_q <= 1'b1;
            if (!in_valid && (idle_cnt_q != '1)) begin
              idle_cnt_q <= idle_cnt_q + 32'd1;
            end
          end
        end
        StSend: begin
          if (out_ready) begin
            if (beat_q == 3'd7) begin
              state_q     <= StIdle;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              rec_count_q <= rec_count_q + 32'd1;
              if (is_hb_q) begin
                hb_count_q <= hb_count_q + 32'd1;
              end
            end else begin
              beat_q     <= beat_q + 3'd1;
              out_data_q <= shift_q[511:448];
              shift_q    <= {shift_q[447:0], 64'h0};
              out_last_q <= (beat_q == 3'd6);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign rec_count = rec_count_q;
  assign hb_count  = hb_count_q;

endmodule
